sw_responder: RTL and testbench

SW_RESPONDER -- requirements
Module: sw_responder

---
 rtl/sw_responder.sv | 208 ++++++++++++++++++++
 tb/tb_sw_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_responder.sv
// Single-wire request/response endpoint. It receives one UART-style byte, then
// after a fixed turnaround it optionally drives one reply byte on the same wire.
module sw_responder #(
  parameter int BIT_CYC  = 8,
  parameter int TURN_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        dinout,
  output logic       oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ack,
  output logic       busy
);

  localparam int CW = $clog2(BIT_CYC + TURN_CYC + 1);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] C_TURN      = CW'(TURN_CYC);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_START,
    ST_RX_DATA,
    ST_RX_STOP,
    ST_TURN,
    ST_TX_START,
    ST_TX_DATA,
    ST_TX_STOP,
    ST_WAIT_HI
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [1:0]    r_blank;
  logic [7:0]    r_rx_sh;
  logic [7:0]    r_tx_sh;
  logic          r_oe;
  logic          r_tx_bit;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_rx_err;
  logic          r_tx_ack;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync_d;
  logic          w_fall;

  assign dinout   = r_oe ? r_tx_bit : 1'bz;
  assign oe       = r_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_err   = r_rx_err;
  assign tx_ack   = r_tx_ack;
  assign busy     = (r_state != ST_IDLE);
  assign w_fall   = r_sync_d & ~r_sync2;

  // Line synchronizer resets to the idle (pulled-up) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= dinout;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_blank    <= '0;
      r_rx_sh    <= '0;
      r_tx_sh    <= '0;
      r_oe       <= 1'b0;
      r_tx_bit   <= 1'b1;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      r_tx_ack   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      r_tx_ack   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Synchronizer still holds our own drive for two cycles after a reply.
          if (r_blank != 2'd0) begin
            r_blank <= r_blank - 2'd1;
          end else if (w_fall) begin
            r_state <= ST_RX_START;
            r_cnt   <= C_HALF_LAST;
            r_bit   <= '0;
          end
        end
        ST_RX_START: begin
          if (r_cnt == '0) begin
            if (r_sync2) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_RX_DATA;
              r_cnt   <= C_BIT_LAST;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RX_DATA: begin
          if (r_cnt == '0) begin
            r_rx_sh <= {r_sync2, r_rx_sh[7:1]};
            r_cnt   <= C_BIT_LAST;
            if (r_bit == 3'd7) begin
              r_state <= ST_RX_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RX_STOP: begin
          if (r_cnt == '0) begin
            if (r_sync2) begin
              r_rx_data  <= r_rx_sh;
              r_rx_valid <= 1'b1;
              r_state    <= ST_TURN;
              r_cnt      <= C_TURN;
            end else begin
              r_rx_err <= 1'b1;
              r_state  <= ST_WAIT_HI;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (r_sync2) begin
            r_state <= ST_IDLE;
          end
        end
        ST_TURN: begin
          // The rx_valid cycle plus TURN_CYC idle clocks precede the start bit.
          if (r_cnt == '0) begin
            if (tx_valid) begin
              r_tx_sh  <= tx_data;
              r_tx_ack <= 1'b1;
              r_oe     <= 1'b1;
              r_tx_bit <= 1'b0;
              r_cnt    <= C_BIT_LAST;
              r_state  <= ST_TX_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_TX_START: begin
          if (r_cnt == '0) begin
            r_tx_bit <= r_tx_sh[0];
            r_tx_sh  <= {1'b1, r_tx_sh[7:1]};
            r_bit    <= '0;
            r_cnt    <= C_BIT_LAST;
            r_state  <= ST_TX_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_TX_DATA: begin
          if (r_cnt == '0) begin
            r_cnt <= C_BIT_LAST;
            if (r_bit == 3'd7) begin
              r_tx_bit <= 1'b1;
              r_state  <= ST_TX_STOP;
            end else begin
              r_tx_bit <= r_tx_sh[0];
              r_tx_sh  <= {1'b1, r_tx_sh[7:1]};
              r_bit    <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_TX_STOP: begin
          if (r_cnt == '0) begin
            r_oe     <= 1'b0;
            r_tx_bit <= 1'b1;
            r_blank  <= 2'd2;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_responder.sv
// Directed bench for sw_responder: an initiator model drives request frames and
// a negedge monitor records pulses and reply frames for checking.
module tb_sw_responder;
  localparam int BIT  = 8;
  localparam int TURN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drv_en = 1'b0;
  logic       drv_val = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  wire        line;
  logic       oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       tx_ack;
  logic       busy;

  assign line = drv_en ? drv_val : 1'bz;
  pullup (line);

  sw_responder #(.BIT_CYC(BIT), .TURN_CYC(TURN)) dut (
    .clk(clk), .rst_n(rst_n), .dinout(line), .oe(oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n_rxv = 0, n_rxe = 0, n_ack = 0, n_overlap = 0;
  int rxv_cyc = 0, ack_cyc = 0, oe_rise_cyc = 0;
  int n_oe_cyc = 0, oe_run = 0, last_len = 0, n_reply = 0;
  logic [9:0] cur_frame = '0;
  logic [9:0] last_frame = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin n_rxv++; rxv_cyc = cyc; end
    if (rx_err) n_rxe++;
    if (tx_ack) begin n_ack++; ack_cyc = cyc; end
    if ((int'(rx_valid) + int'(rx_err) + int'(tx_ack)) > 1) n_overlap++;
    if (oe) begin
      if (oe_run == 0) oe_rise_cyc = cyc;
      if ((oe_run % BIT) == BIT / 2 && oe_run < 10 * BIT) cur_frame[oe_run / BIT] = line;
      oe_run++;
      n_oe_cyc++;
    end else if (oe_run != 0) begin
      last_frame = cur_frame;
      last_len   = oe_run;
      n_reply++;
      oe_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val);
    drv_en = 1'b1;
    drv_val = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      drv_val = data[i];
      tick(BIT);
    end
    drv_val = stop_val;
    tick(BIT);
    drv_en = 1'b0;
    drv_val = 1'b1;
  endtask

  task automatic wait_reply(input int prev, input string tag);
    for (int i = 0; i < 400 && n_reply == prev; i++) tick(1);
    chk(tag, n_reply - prev, 1);
  endtask

  int s_rxv, s_rxe, s_ack, s_oe, s_rep;

  task automatic snap();
    s_rxv = n_rxv; s_rxe = n_rxe; s_ack = n_ack; s_oe = n_oe_cyc; s_rep = n_reply;
  endtask

  initial begin
    tick(3);
    chk("rst_oe", oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_pulses", {rx_valid, rx_err, tx_ack}, 3'b000);
    chk("rst_line", line, 1);
    rst_n = 1'b1;
    tick(4);

    // Request A5, reply 3C; tx_data changed right after capture
    snap();
    tx_data = 8'h3C; tx_valid = 1'b1;
    send_frame(8'hA5, 1'b1);
    for (int i = 0; i < 50 && !tx_ack; i++) tick(1);
    tx_data = 8'hC3;
    wait_reply(s_rep, "a5_reply_done");
    chk("a5_rxv", n_rxv - s_rxv, 1);
    chk("a5_rx_data", rx_data, 8'hA5);
    chk("a5_ack", n_ack - s_ack, 1);
    chk("a5_latency", oe_rise_cyc - rxv_cyc, TURN + 1);
    chk("a5_ack_pos", ack_cyc - rxv_cyc, TURN + 1);
    chk("a5_oe_len", last_len, 10 * BIT);
    chk("a5_frame", last_frame, 10'h278);
    tick(4);
    chk("a5_busy_end", busy, 0);

    // Request 5A, no reply
    snap();
    tx_valid = 1'b0;
    send_frame(8'h5A, 1'b1);
    tick(20);
    chk("5a_rxv", n_rxv - s_rxv, 1);
    chk("5a_rx_data", rx_data, 8'h5A);
    chk("5a_no_oe", n_oe_cyc - s_oe, 0);
    chk("5a_busy", busy, 0);

    // Request FF with bad stop bit, line held low afterwards
    snap();
    send_frame(8'hFF, 1'b0);
    drv_en = 1'b1; drv_val = 1'b0;
    tick(20);
    chk("ff_err", n_rxe - s_rxe, 1);
    chk("ff_no_rxv", n_rxv - s_rxv, 0);
    chk("ff_rx_data", rx_data, 8'h5A);
    chk("ff_busy_low", busy, 1);
    drv_en = 1'b0; drv_val = 1'b1;
    tick(6);
    chk("ff_busy_rel", busy, 0);

    // 3-clock glitch, then request 01
    snap();
    drv_en = 1'b1; drv_val = 1'b0;
    tick(3);
    drv_en = 1'b0; drv_val = 1'b1;
    tick(20);
    chk("gl_no_pulse", (n_rxv - s_rxv) + (n_rxe - s_rxe), 0);
    chk("gl_busy", busy, 0);
    send_frame(8'h01, 1'b1);
    tick(20);
    chk("gl_rxv", n_rxv - s_rxv, 1);
    chk("gl_rx_data", rx_data, 8'h01);

    // Reset during TX data bit 3
    tx_data = 8'h96; tx_valid = 1'b1;
    send_frame(8'h33, 1'b1);
    for (int i = 0; i < 50 && !oe; i++) tick(1);
    chk("rs_oe_start", oe, 1);
    tick(4 * BIT + 3);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_oe_async", oe, 0);
    chk("rs_busy", busy, 0);
    chk("rs_rx_data", rx_data, 8'h00);
    chk("rs_pulses", {rx_valid, rx_err, tx_ack}, 3'b000);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    snap();
    tick(100);
    chk("rs_no_resume", n_oe_cyc - s_oe, 0);
    tx_data = 8'h81;
    send_frame(8'h44, 1'b1);
    wait_reply(s_rep, "rs_reply_done");
    chk("rs_rx_data2", rx_data, 8'h44);
    chk("rs_frame", last_frame, 10'h302);

    // Back-to-back requests 11 then 22
    tick(4);
    snap();
    tx_data = 8'hA1;
    send_frame(8'h11, 1'b1);
    wait_reply(s_rep, "bb1_reply_done");
    chk("bb1_rx_data", rx_data, 8'h11);
    chk("bb1_frame", last_frame, 10'h342);
    tick(4);
    tx_data = 8'hB2;
    send_frame(8'h22, 1'b1);
    wait_reply(s_rep + 1, "bb2_reply_done");
    chk("bb2_rx_data", rx_data, 8'h22);
    chk("bb2_frame", last_frame, 10'h364);
    chk("bb_rxv", n_rxv - s_rxv, 2);
    chk("bb_ack", n_ack - s_ack, 2);
    chk("no_overlap", n_overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
